pc_gen: RTL and testbench

//  Parametrised stage-1 next-PC generator; successor of the single-source PC register.

---
 rtl/pc_gen_pkg.sv | 22 ++
 rtl/pc_redir_arb.sv | 24 ++
 rtl/pc_gen.sv | 147 ++++++++++++++
 tb/tb_pc_gen.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the stage-1 next-PC generator: FSM state encoding,
// default vector constants and the debug view of the generator's control state.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      PCG_BOOT = 2'd0,
      PCG_RUN  = 2'd1,
      PCG_HOLD = 2'd2
   } pcg_state_e;

   localparam logic [31:0] PCG_RESET_VEC = 32'h0000_2000;
   localparam logic [31:0] PCG_TRAP_VEC  = 32'h0000_0100;
   localparam int          PCG_STEP      = 4;

   // Control-state snapshot that checkers can bind to without touching the port list.
   typedef struct packed {
      pcg_state_e state;
      logic       valid;
      logic       mis;
   } pcg_dbg_t;

endpackage

// File: rtl/pc_redir_arb.sv
// Fixed-priority redirect arbiter: the lowest-index requesting source wins and
// its target is forwarded. Purely combinational.
module pc_redir_arb #(
   parameter int XLEN = 32,
   parameter int NRED = 2
) (
   input  logic [NRED-1:0]      redir_valid,
   input  logic [NRED*XLEN-1:0] redir_target,
   output logic                 any,
   output logic [XLEN-1:0]      sel_target
);

   always_comb begin
      any        = |redir_valid;
      sel_target = '0;
      // Walk from the lowest priority upward so the last hit (lowest index) wins.
      for (int i = NRED - 1; i >= 0; i--) begin
         if (redir_valid[i]) begin
            sel_target = redir_target[i*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: rtl/pc_gen.sv
// Stage-1 next-PC generator with prioritised redirects, stall, held redirects
// and a boot cycle. Optional misaligned-target trap enabled by PC_MISALIGN_EN.
module pc_gen
   import pc_gen_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = XLEN'(PCG_RESET_VEC),
   parameter int              STEP      = PCG_STEP,
   parameter int              NRED      = 2,
   parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(PCG_TRAP_VEC)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 stall,
   input  logic [NRED-1:0]      redir_valid,
   input  logic [NRED*XLEN-1:0] redir_target,
   output logic [XLEN-1:0]      pc_out,
   output logic                 pc_valid,
   output logic                 redir_pending,
   output logic                 misalign
);

`ifdef PC_MISALIGN_EN
   localparam bit MIS_EN = 1'b1;
`else
   localparam bit MIS_EN = 1'b0;
`endif

   // Alignment bits are the low log2(STEP) bits; STEP=1 yields an empty mask.
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(STEP - 1);
   localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);

   pcg_state_e      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] pend_q, pend_d;
   logic            mis_q, mis_d;

   logic            any;
   logic [XLEN-1:0] sel_target;

   logic            load_en;
   logic [XLEN-1:0] load_raw;
   logic            load_misaligned;
   logic [XLEN-1:0] load_val;

   pcg_dbg_t        dbg;

   pc_redir_arb #(
      .XLEN (XLEN),
      .NRED (NRED)
   ) u_arb (
      .redir_valid  (redir_valid),
      .redir_target (redir_target),
      .any          (any),
      .sel_target   (sel_target)
   );

   // Redirect sources have no ready: redir_valid[i] is a single-cycle request
   // that is always accepted, either loaded directly or captured into pending
   // while stalled; a request in BOOT or during reset is dropped.

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= PCG_BOOT;
         pc_q    <= RESET_VEC;
         pend_q  <= '0;
         mis_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         pend_q  <= pend_d;
         mis_q   <= mis_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pend_d   = pend_q;
      load_en  = 1'b0;
      load_raw = sel_target;

      case (state_q)
         PCG_BOOT: begin
            state_d = PCG_RUN;
         end

         PCG_RUN: begin
            if (any && !stall) begin
               load_en = 1'b1;
            end else if (any && stall) begin
               pend_d  = sel_target;
               state_d = PCG_HOLD;
            end else if (!stall) begin
               pc_d = pc_q + STEP_INC;
            end
         end

         PCG_HOLD: begin
            if (stall) begin
               // A newer redirect replaces the captured one.
               if (any) begin
                  pend_d = sel_target;
               end
            end else begin
               load_en  = 1'b1;
               load_raw = any ? sel_target : pend_q;
               state_d  = PCG_RUN;
            end
         end

         default: begin
            state_d = PCG_BOOT;
         end
      endcase

      if (load_en) begin
         pc_d = load_val;
      end
   end

   // Alignment is judged on the value actually being loaded, so a held
   // redirect is checked when it leaves pending, not when it was captured.
   always_comb begin
      load_misaligned = |(load_raw & ALIGN_MASK);
      if (MIS_EN && load_misaligned) begin
         load_val = TRAP_VEC;
      end else begin
         load_val = load_raw & ~ALIGN_MASK;
      end
      mis_d = load_en && MIS_EN && load_misaligned;
   end

   assign pc_out        = pc_q;
   assign pc_valid      = (state_q != PCG_BOOT);
   assign redir_pending = (state_q == PCG_HOLD);
   assign misalign      = mis_q;

   assign dbg = '{state: state_q, valid: pc_valid, mis: mis_q};

   a_state_legal : assert property (@(posedge clk) disable iff (reset)
      dbg.state inside {PCG_BOOT, PCG_RUN, PCG_HOLD});

   a_hold_quiet : assert property (@(posedge clk) disable iff (reset)
      (dbg.state == PCG_HOLD) |-> (!dbg.mis && dbg.valid));

endmodule

// File: tb/tb_pc_gen.sv
// Randomised scoreboard bench for pc_gen with a behavioural next-PC model;
// honours PC_MISALIGN_EN when the design is built with it.
module tb_pc_gen;

   localparam int          XLEN      = 32;
   localparam int          NRED      = 2;
   localparam int          STEP      = 4;
   localparam logic [31:0] RESET_VEC = 32'h0000_2000;
   localparam logic [31:0] TRAP_VEC  = 32'h0000_0100;
   localparam int          W         = XLEN + 3;

   logic                 clk;
   logic                 reset;
   logic                 stall;
   logic [NRED-1:0]      redir_valid;
   logic [NRED*XLEN-1:0] redir_target;
   logic [XLEN-1:0]      pc_out;
   logic                 pc_valid;
   logic                 redir_pending;
   logic                 misalign;

   logic [W-1:0] exp_q[$];
   int           n_compared;
   int           n_mismatched;
   int           cyc;

   pc_gen dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .redir_valid   (redir_valid),
      .redir_target  (redir_target),
      .pc_out        (pc_out),
      .pc_valid      (pc_valid),
      .redir_pending (redir_pending),
      .misalign      (misalign)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference model ----------------
   logic [31:0] m_pc;
   logic [31:0] m_pend_tgt;
   bit          m_in_boot;
   bit          m_valid;
   bit          m_pend;
   bit          m_mis;

   task automatic m_load(input logic [31:0] t);
      if ((t % STEP) != 0) begin
`ifdef PC_MISALIGN_EN
         m_pc  = TRAP_VEC;
         m_mis = 1'b1;
`else
         m_pc = t - (t % STEP);
`endif
      end else begin
         m_pc = t;
      end
   endtask

   task automatic m_step(input bit r, input bit s, input logic [1:0] rv,
                         input logic [31:0] t0, input logic [31:0] t1);
      bit          have;
      logic [31:0] win;
      have = (rv != 2'b00);
      win  = rv[0] ? t0 : t1;
      m_mis = 1'b0;
      if (r) begin
         m_pc = RESET_VEC; m_in_boot = 1'b1; m_valid = 1'b0; m_pend = 1'b0;
      end else if (m_in_boot) begin
         m_in_boot = 1'b0; m_valid = 1'b1;
      end else if (m_pend) begin
         if (s) begin
            if (have) m_pend_tgt = win;
         end else begin
            m_pend = 1'b0;
            m_load(have ? win : m_pend_tgt);
         end
      end else if (have && !s) begin
         m_load(win);
      end else if (have && s) begin
         m_pend = 1'b1; m_pend_tgt = win;
      end else if (!s) begin
         m_pc = 32'((64'(m_pc) + 64'(STEP)) % 64'h1_0000_0000);
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input bit r, input bit s, input logic [1:0] rv,
                       input logic [31:0] t0, input logic [31:0] t1);
      reset        = r;
      stall        = s;
      redir_valid  = rv;
      redir_target = {t1, t0};
      @(posedge clk);
      m_step(r, s, rv, t0, t1);
      exp_q.push_back({m_pc, m_valid, m_pend, m_mis});
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b00, $urandom, $urandom);
   endtask

   function automatic logic [31:0] rand_target();
      int k;
      k = $urandom_range(0, 9);
      if (k == 0)      return $urandom;
      else if (k == 1) return 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
      else             return $urandom & 32'hFFFF_FFFC;
   endfunction

   // ---------------- scoreboard monitor ----------------
   initial begin
      logic [W-1:0] e;
      n_compared   = 0;
      n_mismatched = 0;
      cyc          = 0;
      forever begin
         @(negedge clk);
         cyc++;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_compared++;
            if ({pc_out, pc_valid, redir_pending, misalign} !== e) begin
               n_mismatched++;
               $display("FAIL cycle %0d state_check: got pc=%h valid=%b pend=%b mis=%b, expected pc=%h valid=%b pend=%b mis=%b",
                        cyc, pc_out, pc_valid, redir_pending, misalign,
                        e[W-1:3], e[2], e[1], e[0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset = 1'b1; stall = 1'b0; redir_valid = '0; redir_target = '0;
      m_pc = RESET_VEC; m_pend_tgt = '0; m_in_boot = 1'b1;
      m_valid = 1'b0; m_pend = 1'b0; m_mis = 1'b0;

      // reset, boot cycle, then sequential fetch
      repeat (3) step(1'b1, 1'b0, 2'b00, 32'h0, 32'h0);
      idle(4);

      // both sources request: index 0 wins
      step(1'b0, 1'b0, 2'b11, 32'h0000_4000, 32'h0000_3000);
      idle(2);

      // redirect during stall, overwritten by a newer one, released later
      step(1'b0, 1'b1, 2'b10, 32'h0, 32'h0000_5000);
      step(1'b0, 1'b1, 2'b01, 32'h0000_6000, 32'h0);
      step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
      idle(2);

      // wrap-around of the sequential increment
      step(1'b0, 1'b0, 2'b01, 32'hFFFF_FFF8, 32'h0);
      idle(3);

      // reset while holding a redirect
      step(1'b0, 1'b1, 2'b01, 32'h0000_7000, 32'h0);
      step(1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
      step(1'b1, 1'b1, 2'b10, 32'h0, 32'h0000_8000);
      step(1'b0, 1'b1, 2'b11, 32'h0000_9000, 32'h0000_A000);
      idle(2);

      // misaligned redirect, direct and via pending
      step(1'b0, 1'b0, 2'b01, 32'h0000_3002, 32'h0);
      idle(2);
      step(1'b0, 1'b1, 2'b10, 32'h0, 32'h0000_4001);
      step(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
      idle(2);

      // randomised traffic
      for (int i = 0; i < 600; i++) begin
         bit          r;
         bit          s;
         logic [1:0]  rv;
         r  = ($urandom_range(0, 99) < 2);
         s  = ($urandom_range(0, 99) < 35);
         rv = 2'b00;
         if ($urandom_range(0, 99) < 25) rv[0] = 1'b1;
         if ($urandom_range(0, 99) < 25) rv[1] = 1'b1;
         step(r, s, rv, rand_target(), rand_target());
      end
      idle(3);

      for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_mismatched++;
         $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
